// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, BTB entry layout, counter encodings
// and the fetch-PC source select used by pc_btb.
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   // tag holds PC >> (IDX_W+2), so its upper bits stay zero for large tables
   typedef struct packed {
      logic       valid;
      word_t      tag;
      word_t      target;
      logic [1:0] ctr;
   } btb_entry_t;

   localparam logic [1:0] CTR_WEAK_T  = 2'b10;
   localparam logic [1:0] CTR_WEAK_NT = 2'b01;

   typedef enum logic [1:0] {
      NPC_HOLD,
      NPC_REDIRECT,
      NPC_PREDICT
   } npc_sel_t;

   // Fetch addresses are word aligned; the low two bits are dropped on load.
   function automatic word_t word_align(input word_t a);
      return {a[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/pc_btb_if.sv
// Fetch-unit bus: pipeline control, EX redirect/training inputs and the
// fetch address / prediction outputs. master = pc_btb, slave = pipeline.
interface pc_btb_if;
   import cpu_types_pkg::*;

   logic  pc_en;
   logic  ihit;
   logic  bubble;
   logic  redirect;
   word_t redirect_pc;
   logic  upd_en;
   word_t upd_pc;
   word_t upd_target;
   logic  upd_taken;
   word_t imemaddr;
   word_t pc_plus_4;
   logic  pred_taken;
   word_t pred_target;

   modport master (
      input  pc_en, ihit, bubble, redirect, redirect_pc,
      input  upd_en, upd_pc, upd_target, upd_taken,
      output imemaddr, pc_plus_4, pred_taken, pred_target
   );

   modport slave (
      output pc_en, ihit, bubble, redirect, redirect_pc,
      output upd_en, upd_pc, upd_target, upd_taken,
      input  imemaddr, pc_plus_4, pred_taken, pred_target
   );

endinterface

// File: rtl/pc_btb_btb_table.sv
// Direct-mapped branch target buffer: entry storage, combinational read
// port on the fetch PC, and EX-driven counter update / allocation.
module btb_table
   import cpu_types_pkg::*;
#(
   parameter int unsigned BTB_ENTRIES = 16,
   parameter int unsigned IDX_W       = $clog2(BTB_ENTRIES)
) (
   input  logic  CLK,
   input  logic  nRST,
   input  word_t rd_pc,
   output logic  rd_hit,
   output logic  rd_ctr_msb,
   output word_t rd_target,
   input  logic  upd_en,
   input  word_t upd_pc,
   input  word_t upd_target,
   input  logic  upd_taken
);

   localparam int unsigned TAG_LSB = IDX_W + 2;

   btb_entry_t       mem [BTB_ENTRIES];
   logic [IDX_W-1:0] rd_idx;
   logic [IDX_W-1:0] upd_idx;
   word_t            rd_tag;
   word_t            upd_tag;
   btb_entry_t       rd_ent;
   btb_entry_t       upd_ent;
   btb_entry_t       wr_ent;
   logic             upd_hit;
   logic             wr_en;

   // Zero-latency lookup; sees the array contents before any same-cycle write
   always_comb begin
      rd_idx     = IDX_W'(rd_pc >> 2);
      rd_tag     = rd_pc >> TAG_LSB;
      rd_ent     = mem[rd_idx];
      rd_hit     = rd_ent.valid && (rd_ent.tag == rd_tag);
      rd_ctr_msb = rd_ent.ctr[1];
      rd_target  = rd_ent.target;
   end

   // Train on a tag hit, allocate on a taken miss, ignore a not-taken miss
   always_comb begin
      upd_idx = IDX_W'(upd_pc >> 2);
      upd_tag = upd_pc >> TAG_LSB;
      upd_ent = mem[upd_idx];
      upd_hit = upd_ent.valid && (upd_ent.tag == upd_tag);
      wr_en   = 1'b0;
      wr_ent  = upd_ent;
      if (upd_en) begin
         if (upd_hit) begin
            wr_en = 1'b1;
            if (upd_taken) begin
               if (upd_ent.ctr != 2'b11) wr_ent.ctr = upd_ent.ctr + 2'd1;
               wr_ent.target = word_align(upd_target);
            end else begin
               if (upd_ent.ctr != 2'b00) wr_ent.ctr = upd_ent.ctr - 2'd1;
            end
         end else if (upd_taken) begin
            wr_en         = 1'b1;
            wr_ent.valid  = 1'b1;
            wr_ent.tag    = upd_tag;
            wr_ent.target = word_align(upd_target);
            wr_ent.ctr    = CTR_WEAK_T;
         end
      end
   end

   // Entry storage; reset invalidates all entries and sets weakly not-taken
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         for (int unsigned i = 0; i < BTB_ENTRIES; i++) begin
            mem[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_WEAK_NT};
         end
      end else if (wr_en) begin
         mem[upd_idx] <= wr_ent;
      end
   end

endmodule

// File: rtl/pc_btb.sv
// Fetch PC unit with BTB next-PC prediction and EX redirect.
// Optional statistics counters are built when PC_BTB_STATS_EN is defined.
module pc_btb
   import cpu_types_pkg::*;
#(
   parameter word_t       PC_RESET    = 32'h00000000,
   parameter int unsigned BTB_ENTRIES = 16,
   parameter int unsigned IDX_W       = $clog2(BTB_ENTRIES)
) (
   input  logic      CLK,
   input  logic      nRST,
   pc_btb_if.master  bus
`ifdef PC_BTB_STATS_EN
   ,
   output word_t     stat_lookups,
   output word_t     stat_hits,
   output word_t     stat_redirects
`endif
);

   word_t    pc;
   word_t    pc_next;
   npc_sel_t sel;
   logic     hit;
   logic     ctr_msb;
   word_t    btb_target;

   btb_table #(
      .BTB_ENTRIES (BTB_ENTRIES),
      .IDX_W       (IDX_W)
   ) u_table (
      .CLK        (CLK),
      .nRST       (nRST),
      .rd_pc      (pc),
      .rd_hit     (hit),
      .rd_ctr_msb (ctr_msb),
      .rd_target  (btb_target),
      .upd_en     (bus.upd_en),
      .upd_pc     (bus.upd_pc),
      .upd_target (bus.upd_target),
      .upd_taken  (bus.upd_taken)
   );

   // Fetch address and prediction outputs, all combinational on the PC
   always_comb begin
      bus.imemaddr    = pc;
      bus.pc_plus_4   = pc + 32'd4;
      bus.pred_taken  = hit && ctr_msb;
      bus.pred_target = bus.pred_taken ? btb_target : bus.pc_plus_4;
   end

   // Next-PC priority: enable, then redirect, then stall/miss, then predict
   always_comb begin
      sel = NPC_HOLD;
      if (bus.pc_en) begin
         if (bus.redirect)                sel = NPC_REDIRECT;
         else if (!bus.bubble && bus.ihit) sel = NPC_PREDICT;
      end
      case (sel)
         NPC_REDIRECT: pc_next = word_align(bus.redirect_pc);
         NPC_PREDICT:  pc_next = word_align(bus.pred_target);
         default:      pc_next = pc;
      endcase
   end

   // PC register
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) pc <= word_align(PC_RESET);
      else       pc <= pc_next;
   end

`ifdef PC_BTB_STATS_EN
   // Lookup/hit counts on advancing cycles, redirect count on accepted redirects
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         stat_lookups   <= '0;
         stat_hits      <= '0;
         stat_redirects <= '0;
      end else begin
         if (sel == NPC_PREDICT) begin
            stat_lookups <= stat_lookups + 32'd1;
            if (hit) stat_hits <= stat_hits + 32'd1;
         end
         if (sel == NPC_REDIRECT) stat_redirects <= stat_redirects + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_pc_btb.sv
// Bench for pc_btb: directed vectors, an abstract BTB/PC model checked on
// every falling edge, and literal expectations at key points.
module tb_pc_btb;
   localparam int unsigned N   = 16;
   localparam logic [31:0] PCR = 32'h00000000;

   logic CLK  = 1'b0;
   logic nRST = 1'b1;
   int   total = 0;
   int   bad   = 0;

   pc_btb_if bus ();

   pc_btb #(
      .PC_RESET    (PCR),
      .BTB_ENTRIES (N)
   ) dut (
      .CLK  (CLK),
      .nRST (nRST),
      .bus  (bus)
   );

   always #5 CLK = ~CLK;

   // Model: one slot per (pc/4) mod N, identified by pc/(4N)
   logic [31:0] m_pc;
   bit          m_valid [N];
   logic [31:0] m_tag   [N];
   logic [31:0] m_tgt   [N];
   int          m_ctr   [N];

   function automatic int unsigned midx(input logic [31:0] p);
      return (p / 4) % N;
   endfunction

   function automatic logic [31:0] mtag(input logic [31:0] p);
      return p / (4 * N);
   endfunction

   function automatic bit m_taken(input logic [31:0] p);
      int unsigned i;
      i = midx(p);
      return m_valid[i] && (m_tag[i] == mtag(p)) && (m_ctr[i] >= 2);
   endfunction

   function automatic logic [31:0] m_next(input logic [31:0] p);
      return m_taken(p) ? m_tgt[midx(p)] : p + 32'd4;
   endfunction

   always @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         m_pc <= PCR;
         for (int i = 0; i < N; i++) begin
            m_valid[i] <= 1'b0;
            m_ctr[i]   <= 1;
            m_tag[i]   <= '0;
            m_tgt[i]   <= '0;
         end
      end else begin
         if (bus.pc_en) begin
            if (bus.redirect)                 m_pc <= bus.redirect_pc & ~32'd3;
            else if (!bus.bubble && bus.ihit) m_pc <= m_next(m_pc);
         end
         if (bus.upd_en) begin
            if (m_valid[midx(bus.upd_pc)] && m_tag[midx(bus.upd_pc)] == mtag(bus.upd_pc)) begin
               if (bus.upd_taken) begin
                  m_ctr[midx(bus.upd_pc)] <= (m_ctr[midx(bus.upd_pc)] == 3) ? 3 : m_ctr[midx(bus.upd_pc)] + 1;
                  m_tgt[midx(bus.upd_pc)] <= bus.upd_target;
               end else begin
                  m_ctr[midx(bus.upd_pc)] <= (m_ctr[midx(bus.upd_pc)] == 0) ? 0 : m_ctr[midx(bus.upd_pc)] - 1;
               end
            end else if (bus.upd_taken) begin
               m_valid[midx(bus.upd_pc)] <= 1'b1;
               m_tag[midx(bus.upd_pc)]   <= mtag(bus.upd_pc);
               m_tgt[midx(bus.upd_pc)]   <= bus.upd_target;
               m_ctr[midx(bus.upd_pc)]   <= 2;
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model
   always @(negedge CLK) begin
      chk("m_imemaddr",    bus.imemaddr,          m_pc);
      chk("m_pc_plus_4",   bus.pc_plus_4,         m_pc + 32'd4);
      chk("m_pred_taken",  32'(bus.pred_taken),   32'(m_taken(m_pc)));
      chk("m_pred_target", bus.pred_target,       m_next(m_pc));
   end

   task automatic setin(input logic en, input logic ih, input logic bb,
                        input logic rd, input logic [31:0] rpc);
      bus.pc_en       = en;
      bus.ihit        = ih;
      bus.bubble      = bb;
      bus.redirect    = rd;
      bus.redirect_pc = rpc;
   endtask

   task automatic step(input logic en, input logic ih, input logic bb,
                       input logic rd, input logic [31:0] rpc);
      setin(en, ih, bb, rd, rpc);
      @(posedge CLK);
      #2;
      bus.upd_en = 1'b0;
   endtask

   task automatic train(input logic [31:0] p, input logic [31:0] t, input logic tk);
      bus.upd_en     = 1'b1;
      bus.upd_pc     = p;
      bus.upd_target = t;
      bus.upd_taken  = tk;
   endtask

   initial begin
      setin(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      bus.upd_en     = 1'b0;
      bus.upd_pc     = '0;
      bus.upd_target = '0;
      bus.upd_taken  = 1'b0;
      #1 nRST = 1'b0;
      repeat (2) @(posedge CLK);
      #2 nRST = 1'b1;
      chk("rst_pc",   bus.imemaddr,           32'h0);
      chk("rst_pp4",  bus.pc_plus_4,          32'h4);
      chk("rst_pt",   32'(bus.pred_taken),    32'h0);

      // sequential fetch
      step(1, 1, 0, 0, 0); chk("seq_4", bus.imemaddr, 32'h4);
      step(1, 1, 0, 0, 0); chk("seq_8", bus.imemaddr, 32'h8);
      step(1, 1, 0, 0, 0); chk("seq_c", bus.imemaddr, 32'hc);
      chk("seq_pt", 32'(bus.pred_taken), 32'h0);

      // allocate taken branch at 0x10 -> 0x40
      train(32'h10, 32'h40, 1'b1);
      step(1, 0, 0, 0, 0); chk("miss_hold", bus.imemaddr, 32'hc);
      step(1, 1, 0, 0, 0); chk("tr_pc", bus.imemaddr, 32'h10);
      chk("tr_pt",  32'(bus.pred_taken), 32'h1);
      chk("tr_tgt", bus.pred_target,     32'h40);
      step(1, 1, 0, 0, 0); chk("tr_jump", bus.imemaddr, 32'h40);

      // two not-taken updates: 10 -> 01 -> 00
      train(32'h10, 32'h0, 1'b0); step(1, 0, 0, 0, 0);
      train(32'h10, 32'h0, 1'b0); step(1, 0, 0, 0, 0);
      step(1, 0, 0, 1, 32'h10);
      chk("nt_pt",  32'(bus.pred_taken), 32'h0);
      chk("nt_tgt", bus.pred_target,     32'h14);
      step(1, 1, 0, 0, 0); chk("nt_fall", bus.imemaddr, 32'h14);

      // ihit low holds; redirect wins over ihit=0
      step(1, 0, 0, 0, 0); step(1, 0, 0, 0, 0);
      chk("ih_hold", bus.imemaddr, 32'h14);
      step(1, 0, 0, 1, 32'h200); chk("redir", bus.imemaddr, 32'h200);

      // pc_en=0 blocks redirect; pc_en=1 redirect beats bubble
      step(0, 1, 1, 1, 32'h300); chk("en_block", bus.imemaddr, 32'h200);
      step(1, 1, 1, 1, 32'h300); chk("en_redir", bus.imemaddr, 32'h300);

      // aliasing: 0x50 shares the slot of 0x10 and replaces it
      train(32'h10, 32'h40, 1'b1); step(1, 0, 0, 0, 0);
      train(32'h50, 32'h80, 1'b1); step(1, 0, 0, 0, 0);
      step(1, 0, 0, 1, 32'h50);
      chk("al_pt",  32'(bus.pred_taken), 32'h1);
      chk("al_tgt", bus.pred_target,     32'h80);
      step(1, 0, 0, 1, 32'h10);
      chk("al_miss", 32'(bus.pred_taken), 32'h0);
      chk("al_tgt2", bus.pred_target,     32'h14);

      // same-cycle update and lookup: fetch sees pre-update contents
      train(32'h10, 32'h100, 1'b1);
      step(1, 1, 0, 0, 0); chk("sc_old", bus.imemaddr, 32'h14);
      step(1, 0, 0, 1, 32'h10);
      chk("sc_new_pt",  32'(bus.pred_taken), 32'h1);
      chk("sc_new_tgt", bus.pred_target,     32'h100);

      // wrap at top of address space
      step(1, 0, 0, 1, 32'hfffffffc);
      chk("wrap_pp4", bus.pc_plus_4, 32'h0);
      step(1, 1, 0, 0, 0); chk("wrap_pc", bus.imemaddr, 32'h0);

      // reset pulse during a stalled redirect
      step(1, 0, 0, 1, 32'h10);
      setin(1, 0, 1, 1, 32'h500);
      #1 nRST = 1'b0;
      #1 chk("arst_pc", bus.imemaddr, PCR);
      @(posedge CLK);
      #2;
      setin(1, 1, 0, 0, 0);
      nRST = 1'b1;
      chk("arst_hold", bus.imemaddr, PCR);
      step(1, 1, 0, 0, 0); chk("arst_first", bus.imemaddr, 32'h4);
      step(1, 0, 0, 1, 32'h10);
      chk("arst_miss",  32'(bus.pred_taken), 32'h0);
      chk("arst_miss_t", bus.pred_target,    32'h14);

      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pc_btb.md
Name: pc_btb

Overview:
- Parametrised next-generation fetch PC unit for the pipelined MIPS core.
- Holds the program counter and drives imemaddr to the instruction cache.
- Predicts next PC from a direct-mapped branch target buffer (BTB) with 2-bit saturating counters.
- Accepts a redirect from EX on mispredict or jump-register; trained by EX-stage branch resolution.

Parameters:
- PC_RESET, 32'h00000000, PC value loaded on reset.
- BTB_ENTRIES, 16, number of BTB entries; power of two, 2..256.
- IDX_W, $clog2(BTB_ENTRIES), index width, derived; not overridden.

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- pc_en  in  1  global PC enable; 0 freezes PC and blocks redirect.
- ihit  in  1  instruction cache returned the word at imemaddr this cycle.
- bubble  in  1  hazard-unit stall; holds PC.
- redirect  in  1  EX mispredict/jump: load redirect_pc.
- redirect_pc  in  32  corrected fetch address.
- upd_en  in  1  EX resolved a branch/jump this cycle.
- upd_pc  in  32  PC of the resolved instruction.
- upd_target  in  32  resolved target address.
- upd_taken  in  1  resolved direction.
- imemaddr  out  32  current fetch PC.
- pc_plus_4  out  32  imemaddr + 4.
- pred_taken  out  1  BTB predicts taken for imemaddr; piped down for EX compare.
- pred_target  out  32  predicted next PC (target if pred_taken, else pc_plus_4).

Behaviour:
- Reset (async, nRST=0):
  - PC = PC_RESET.
  - All BTB valid bits = 0; counters = 2'b01.
  - Outputs follow combinationally: pc_plus_4 = PC_RESET+4, pred_taken = 0.
- Index = PC[IDX_W+1:2]; tag = PC[31:IDX_W+2]; PC[1:0] ignored and forced to 0 on load.
- Lookup is combinational on PC, zero-cycle latency:
  - hit = valid[idx] && tag match.
  - pred_taken = hit && ctr[idx][1].
  - pred_target = pred_taken ? target[idx] : PC+4.
- PC next-state priority, evaluated each rising edge:
  - 1. pc_en=0: hold.
  - 2. redirect=1: PC <= redirect_pc, regardless of ihit/bubble; cancels the outstanding fetch.
  - 3. bubble=1 or ihit=0: hold.
  - 4. else: PC <= pred_target.
- BTB update on upd_en (independent of pc_en/bubble):
  - Tag hit:
    - ctr saturating inc if taken, dec if not; 2'b11 and 2'b00 saturate.
    - target <= upd_target when taken.
  - Tag miss and taken: allocate/replace entry with valid=1, tag, target, ctr=2'b10.
  - Tag miss and not taken: no write.
- Same-cycle lookup and update on the same index: lookup sees pre-update contents; new contents visible next cycle.
- Address arithmetic is modulo 2^32; 32'hFFFFFFFC + 4 wraps to 0.
- Reset asserted mid-stall or mid-redirect: state clears immediately; first fetch after release is PC_RESET.

Optional Feature:
- PC_BTB_STATS_EN defined:
  - Adds outputs stat_lookups[31:0], stat_hits[31:0], stat_redirects[31:0].
  - stat_lookups and stat_hits count each advancing cycle (priority 4) and hit.
  - stat_redirects counts accepted redirects.
  - All three wrap at 2^32 and reset to 0.
- Undefined: the outputs and counters are absent; behaviour otherwise identical.

Decomposition:
- cpu_types_pkg gains btb_entry_t (valid, tag, target word_t, ctr[1:0]) and the constants CTR_WEAK_T=2'b10 and CTR_WEAK_NT=2'b01.
- word_t is reused from cpu_types_pkg.
- One sub-module, btb_table: storage array, combinational read port, and update/allocate logic.
- pc_btb holds the PC register, next-PC mux and the optional stats.

Test Plan:
- Reset release with PC_RESET=32'h0, ihit=1 for 3 cycles -> imemaddr 0, 4, 8, 12; pred_taken=0 throughout.
- Train branch at PC 32'h10 with upd_en, upd_taken=1, target 32'h40; refetch 32'h10 -> pred_taken=1, next imemaddr 32'h40.
- Two not-taken updates to PC 32'h10 after allocation (ctr 10->01->00) -> pred_taken=0, next imemaddr 32'h14.
- ihit=0 for 2 cycles, then redirect=1 with redirect_pc 32'h200 while ihit=0 -> PC held, then 32'h200 next edge.
- bubble=1 with pc_en=0 and redirect=1 -> PC unchanged; pc_en=1 -> redirect taken.
- Aliasing: PCs 32'h10 and 32'h10+4*BTB_ENTRIES, both taken -> second replaces first; 32'h10 then misses.
- nRST pulse mid-run -> imemaddr=PC_RESET asynchronously; all entries miss afterwards.
